// File: rtl/regfile_pkg.sv
// Shared constants and index type for the multi-port register file.
package regfile_pkg;

    localparam int REGFILE_N     = 16;
    localparam int REGFILE_DEPTH = 8;

    typedef logic [$clog2(REGFILE_DEPTH)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_entry.sv
// One storage word: load-enable register with synchronous active-low reset.
module regfile_entry #(
    parameter int             N         = 16,
    parameter logic [N-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised 2-read/1-write register file with per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int           N         = REGFILE_N,
    parameter int           DEPTH     = REGFILE_DEPTH,
    parameter logic [N-1:0] RESET_VAL = '0,
    localparam int          AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  data_in,
    input  logic [AW-1:0] writenum,
    input  logic          write,
    input  logic [AW-1:0] readnum_a,
    output logic [N-1:0]  data_out_a,
    output logic          busy_a,
    input  logic [AW-1:0] readnum_b,
    output logic [N-1:0]  data_out_b,
    output logic          busy_b,
    input  logic          rsv,
    input  logic [AW-1:0] rsvnum,
    output logic          rsv_err,
    output logic          any_busy
);

    logic [N-1:0]     regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic             rsv_err_next;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        regfile_entry #(
            .N         (N),
            .RESET_VAL (RESET_VAL)
        ) u_entry (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (write && (writenum == AW'(i))),
            .d     (data_in),
            .q     (regs[i])
        );
    end

    // A write releases its destination; a reserve in the same cycle re-claims it,
    // so the reserve is only an error when the register stays held.
    always_comb begin
        busy_next = busy;
        if (write) begin
            busy_next[writenum] = 1'b0;
        end
        if (rsv) begin
            busy_next[rsvnum] = 1'b1;
        end
        rsv_err_next = rsv && busy[rsvnum] && !(write && (writenum == rsvnum));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= '0;
            rsv_err <= 1'b0;
        end else begin
            busy    <= busy_next;
            rsv_err <= rsv_err_next;
        end
    end

    assign any_busy = |busy;

`ifdef REGFILE_BYPASS_EN
    logic fwd_a;
    logic fwd_b;

    assign fwd_a = write && (writenum == readnum_a);
    assign fwd_b = write && (writenum == readnum_b);

    // Forwarded ports show the post-edge view of both data and busy.
    always_comb begin
        data_out_a = fwd_a ? data_in : regs[readnum_a];
        data_out_b = fwd_b ? data_in : regs[readnum_b];
        busy_a     = fwd_a ? (rsv && (rsvnum == readnum_a)) : busy[readnum_a];
        busy_b     = fwd_b ? (rsv && (rsvnum == readnum_b)) : busy[readnum_b];
    end
`else
    always_comb begin
        data_out_a = regs[readnum_a];
        data_out_b = regs[readnum_b];
        busy_a     = busy[readnum_a];
        busy_b     = busy[readnum_b];
    end
`endif

endmodule
